// File: rtl/river_pkg.sv
// Shared types and defaults for the scrolling river boundary ring.
package river_pkg;

    localparam int DATA_W_DEF   = 10;
    localparam int CHANNELS_DEF = 2;
    localparam int ROW_W_DEF    = DATA_W_DEF * CHANNELS_DEF;

    typedef logic [CHANNELS_DEF-1:0][DATA_W_DEF-1:0] boundary_row_t;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SCROLL
    } state_t;

endpackage

// File: rtl/river_boundary_ring_ram.sv
// Simple dual-port row store, read-first, no reset on contents.
module boundary_ram
    import river_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ROW_W  = ROW_W_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [ROW_W-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [ROW_W-1:0]  o_q
);

    logic [ROW_W-1:0] r_mem [DEPTH];
    logic [ROW_W-1:0] r_q;

    // Nonblocking write and read in one block gives old data on a collision.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/river_boundary_ring.sv
// Ring of boundary rows: head-pointer scrolling, atomic view commit.
module river_boundary_ring
    import river_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = 256,
    parameter int CHANNELS   = CHANNELS_DEF,
    parameter int MAX_SCROLL = 8,
    parameter int INIT_POS   = 0,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int SCROLL_W  = $clog2(MAX_SCROLL + 1),
    localparam int ROW_W     = CHANNELS * DATA_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                scroll_req,
    input  logic [SCROLL_W-1:0] scroll_amt,
    input  logic                push_valid,
    input  logic [ROW_W-1:0]    push_data,
    output logic                push_ready,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [ROW_W-1:0]    rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                init_done,
    output logic                scroll_done
);

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0]   r_init_cnt;
    logic [ADDR_W-1:0]   r_work_head;
    logic [ADDR_W-1:0]   r_view_head;
    logic [SCROLL_W-1:0] r_remaining;
    logic                r_init_done;
    logic                r_scroll_done;
    logic                r_rd_valid;

    logic [SCROLL_W-1:0] w_amt;
    logic [ADDR_W-1:0]   w_head_dec;
    logic [ADDR_W-1:0]   w_raddr;
    logic [ADDR_W-1:0]   w_waddr;
    logic [ROW_W-1:0]    w_wdata;
    logic [ROW_W-1:0]    w_q;
    logic [DATA_W-1:0]   w_init_pos;
    logic                w_we;
    logic                w_push_ready;
    logic                w_busy;
    logic                w_push_hs;
    logic                w_last_hs;
    logic                w_init_last;

    assign w_init_pos  = DATA_W'(INIT_POS);
    assign w_amt       = (scroll_amt > SCROLL_W'(MAX_SCROLL)) ?
                         SCROLL_W'(MAX_SCROLL) : scroll_amt;
    assign w_head_dec  = r_work_head - ADDR_W'(1);
    assign w_push_hs   = push_valid && w_push_ready;
    assign w_last_hs   = w_push_hs && (r_remaining == SCROLL_W'(1));
    assign w_init_last = (r_init_cnt == ADDR_W'(DEPTH - 1));
    assign w_raddr     = r_view_head + rd_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_INIT: begin
                if (w_init_last) begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (scroll_req && (w_amt != '0)) begin
                    w_next = S_SCROLL;
                end
            end
            S_SCROLL: begin
                if (w_last_hs) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_INIT;
        endcase
    end

    // The INIT sweep and the scroll writer share the single RAM write port.
    always_comb begin
        w_push_ready = 1'b0;
        w_busy       = 1'b1;
        w_we         = 1'b0;
        w_waddr      = r_init_cnt;
        w_wdata      = {CHANNELS{w_init_pos}};
        unique case (r_state)
            S_INIT: begin
                w_we = 1'b1;
            end
            S_IDLE: begin
                w_busy = 1'b0;
            end
            S_SCROLL: begin
                w_push_ready = 1'b1;
                w_we         = push_valid;
                w_waddr      = w_head_dec;
                w_wdata      = push_data;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init_cnt    <= '0;
            r_work_head   <= '0;
            r_view_head   <= '0;
            r_remaining   <= '0;
            r_init_done   <= 1'b0;
            r_scroll_done <= 1'b0;
            r_rd_valid    <= 1'b0;
        end else begin
            r_scroll_done <= 1'b0;
            r_rd_valid    <= rd_en && (r_state != S_INIT);
            unique case (r_state)
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + ADDR_W'(1);
                    if (w_init_last) begin
                        r_init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (scroll_req) begin
                        if (w_amt == '0) begin
                            r_scroll_done <= 1'b1;
                        end else begin
                            r_remaining <= w_amt;
                        end
                    end
                end
                S_SCROLL: begin
                    if (w_push_hs) begin
                        r_work_head <= w_head_dec;
                        r_remaining <= r_remaining - SCROLL_W'(1);
                    end
                    // View jumps to the newest row only once the whole scroll is in.
                    if (w_last_hs) begin
                        r_view_head   <= w_head_dec;
                        r_scroll_done <= 1'b1;
                    end
                end
                default: begin
                    r_remaining <= '0;
                end
            endcase
        end
    end

    boundary_ram #(
        .DEPTH (DEPTH),
        .ROW_W (ROW_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (rd_en),
        .i_raddr (w_raddr),
        .o_q     (w_q)
    );

    assign rd_data     = r_rd_valid ? w_q : '0;
    assign rd_valid    = r_rd_valid;
    assign push_ready  = w_push_ready;
    assign busy        = w_busy;
    assign init_done   = r_init_done;
    assign scroll_done = r_scroll_done;

endmodule

// File: doc/river_boundary_ring.md
Name: river_boundary_ring

Overview:
- Parametrised successor to the single-channel boundary shift store for the scrolling river playfield.
- Holds DEPTH screen rows; each row carries CHANNELS boundary x-positions (e.g. left bank, right bank, island edges).
- Scrolling moves a ring head pointer; no data is shifted. Multi-row scrolls consume new top rows from the terrain generator over a ready/valid handshake.
- The display reads by logical row (0 = top). The view commits atomically when a scroll completes.

Parameters:
- DATA_W, 10, width of one boundary x-position.
- DEPTH, 256, number of rows (power of 2).
- CHANNELS, 2, positions per row.
- MAX_SCROLL, 8, maximum rows per scroll request.
- INIT_POS, 0, value written to every channel of every row during initialisation.
- Derived: ADDR_W = $clog2(DEPTH); SCROLL_W = $clog2(MAX_SCROLL+1); ROW_W = CHANNELS*DATA_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- scroll_req  in  1  start a scroll; sampled only in IDLE.
- scroll_amt  in  SCROLL_W  rows to scroll; clamped to MAX_SCROLL.
- push_valid  in  1  generator presents a new row.
- push_data  in  ROW_W  new row; channel k occupies bits [k*DATA_W +: DATA_W].
- push_ready  out  1  row accepted when push_valid && push_ready.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  logical row, 0 = top of screen.
- rd_data  out  ROW_W  registered read data.
- rd_valid  out  1  rd_data valid; 1 cycle after rd_en.
- busy  out  1  high in INIT and SCROLL.
- init_done  out  1  sticky high once INIT completes.
- scroll_done  out  1  one-cycle pulse when a scroll commits.

Behaviour:
- Reset (async assert, sync release):
  - state=INIT, init_cnt=0, work_head=0, view_head=0.
  - rd_data=0, rd_valid=0, push_ready=0, busy=1, init_done=0, scroll_done=0.
  - Memory contents are not reset.
- INIT:
  - Writes INIT_POS to every channel of physical entry init_cnt, one entry per cycle.
  - After entry DEPTH-1 is written, moves to IDLE; init_done rises on the first IDLE cycle (DEPTH cycles after reset release).
  - rd_en is ignored in INIT; rd_valid stays 0.
- IDLE:
  - busy=0, push_ready=0.
  - scroll_req with effective amount n = min(scroll_amt, MAX_SCROLL):
    - n=0: stay in IDLE; scroll_done pulses the next cycle.
    - n>0: load remaining=n; go to SCROLL.
- SCROLL:
  - push_ready=1.
  - On each handshake: work_head <= work_head-1 (mod DEPTH); write push_data to the new work_head; remaining--.
  - push_valid low: wait indefinitely, no timeout, state held.
  - On the handshake with remaining==1: next cycle view_head <= work_head, scroll_done=1, go to IDLE, push_ready drops the same cycle.
  - The last row pushed becomes logical row 0; earlier rows of the same scroll sit below it in push order reversed.
  - scroll_req in SCROLL is ignored (not queued).
- Read path:
  - Physical address = view_head + rd_addr, mod DEPTH (ADDR_W-bit wrap).
  - 1-cycle latency; rd_valid mirrors rd_en delayed by one cycle, in IDLE and SCROLL.
  - Same-cycle read and write to one physical entry returns old data (read-first).
  - During SCROLL, rows 0..DEPTH-1-k stay stable, where k = rows pushed so far. The bottom k logical rows alias freshly written entries and may show new data. Scrolls are issued in vblank.
- Wrap-around: head arithmetic is modulo DEPTH in both directions; no full/empty condition, because the ring is always fully populated.
- Reset mid-SCROLL: pushed rows are abandoned, view_head returns to 0, INIT reruns, and no scroll_done is pulsed.

Decomposition:
- Package river_pkg:
  - DATA_W / ROW_W defaults.
  - Typedef boundary_row_t (packed array [CHANNELS] of logic [DATA_W-1:0]).
  - State enum {INIT, IDLE, SCROLL}.
- Sub-module boundary_ram:
  - Simple dual-port, DEPTH x ROW_W.
  - One write port, one registered read-first read port, no reset.
  - Shared by the INIT writer and the SCROLL writer through a write mux in the top level.

Test Plan:
1. Release reset_n → init_done rises exactly 256 cycles later. Reads of rows 0, 128, 255 return {0,0} with rd_valid one cycle after rd_en.
2. scroll_amt=1, push {100,500} → scroll_done pulses once. Row 0 = {100,500}; row 1 = {0,0}; busy low the following cycle.
3. scroll_amt=3, push A={1,2}, B={3,4}, C={5,6} → row0=C, row1=B, row2=A. Repeat with scroll_amt=12: exactly 8 rows consumed, push_ready low afterwards. scroll_amt=0 → scroll_done next cycle, no data change.
4. scroll_amt=3, push_valid low for 5 cycles after the first row → busy stays 1 and push_ready stays 1. scroll_done comes only after the third handshake. Row 0 reads the pre-scroll value until commit.
5. 260 single-row scrolls pushing {i,i} for i=0..259 → row0={259,259}, row255={4,4}; head wrap is seamless.
6. Assert reset_n mid-SCROLL after 1 of 4 rows → no scroll_done, busy=1, INIT reruns. After 256 cycles every row reads {0,0} and view_head=0.
